// File: rtl/div_arbiter_if.sv
// -----------------------------------------------------------------------------
// div_arbiter_if
// Bundle of the requester-side and divider-side signals of div_arbiter.
//
// Parameters:
//   N    - operand/quotient width including sign bit
//   NREQ - number of requesters
//
// Modports:
//   slave  - the arbiter's view (drives o_*, samples i_*)
//   master - the environment's view (requesters plus divider)
//
// Signals (requester k uses bits [k*N +: N] of the packed operand buses):
//   i_req, i_dividend, i_divisor   requests and operands in
//   o_gnt, o_done                  one-hot, single-cycle pulses
//   o_quotient, o_overflow         result broadcast to all requesters
//   o_busy                         high whenever a division is in progress
//   o_div_*                        start pulse and latched operands to divider
//   i_div_*                        divider completion level and result
// -----------------------------------------------------------------------------
interface div_arbiter_if #(
  parameter int N    = 32,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   i_req;
  logic [NREQ*N-1:0] i_dividend;
  logic [NREQ*N-1:0] i_divisor;
  logic [NREQ-1:0]   o_gnt;
  logic [NREQ-1:0]   o_done;
  logic [N-1:0]      o_quotient;
  logic              o_overflow;
  logic              o_busy;
  logic              o_div_start;
  logic [N-1:0]      o_div_dividend;
  logic [N-1:0]      o_div_divisor;
  logic              i_div_complete;
  logic [N-1:0]      i_div_quotient;
  logic              i_div_overflow;

  modport slave (
    input  i_req, i_dividend, i_divisor,
    input  i_div_complete, i_div_quotient, i_div_overflow,
    output o_gnt, o_done, o_quotient, o_overflow, o_busy,
    output o_div_start, o_div_dividend, o_div_divisor
  );

  modport master (
    output i_req, i_dividend, i_divisor,
    output i_div_complete, i_div_quotient, i_div_overflow,
    input  o_gnt, o_done, o_quotient, o_overflow, o_busy,
    input  o_div_start, o_div_dividend, o_div_divisor
  );
endinterface

// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
// Round-robin arbiter and sequencer sharing one signed fixed-point divider
// between NREQ requesters. The winner's operands are latched, the divider is
// started once, and the result is returned with a one-hot o_done pulse.
//
// Parameters:
//   N    - operand/quotient width incl. sign bit (must match the interface)
//   Q    - fractional bits; informational, only range-checked here
//   NREQ - number of requesters, 2..16
//
// Ports:
//   i_clk   - clock
//   i_rstn  - asynchronous active-low reset
//   bus     - div_arbiter_if.slave: requests/operands in, grant/done/result
//             out, plus the divider start/operand/complete/result signals
//
// Timing (edges counted from the arbitration edge that raises o_gnt):
//   o_div_start is high the cycle after o_gnt; o_done follows o_gnt by
//   divider latency + 4 cycles.
//
// Optional feature (macro DIV_ZERO_BYPASS_EN):
//   A zero divisor is answered directly with a saturated quotient and
//   o_overflow=1, without starting the divider.
// -----------------------------------------------------------------------------
module div_arbiter #(
  parameter int N    = 32,
  parameter int Q    = 15,
  parameter int NREQ = 4
) (
  input logic          i_clk,
  input logic          i_rstn,
  div_arbiter_if.slave bus
);

  localparam int PW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("div_arbiter: NREQ must be in 2..16");
  end
  if (Q < 0 || Q >= N) begin : g_bad_q
    $error("div_arbiter: Q must be in 0..N-1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GUARD,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     last_q, last_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              start_q, start_d;
  logic [N-1:0]      dvd_q, dvd_d;
  logic [N-1:0]      dvs_q, dvs_d;
  logic [N-1:0]      quot_q, quot_d;
  logic              ovf_q, ovf_d;

  logic [PW-1:0]     win_idx;
  logic [N-1:0]      win_dvd;
  logic [N-1:0]      win_dvs;

  // Round-robin search: scan from farthest to nearest so the last hit is the
  // first requester after 'last'. The previous winner therefore comes last.
  always_comb begin
    win_idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      if (bus.i_req[(int'(last_q) + i) % NREQ]) begin
        win_idx = PW'((int'(last_q) + i) % NREQ);
      end
    end
  end

  assign win_dvd = bus.i_dividend[int'(win_idx)*N +: N];
  assign win_dvs = bus.i_divisor[int'(win_idx)*N +: N];

  // NOTE: every variable gets its hold/idle default before the case; a path
  // that forgets one would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    gnt_d   = '0;
    done_d  = '0;
    start_d = 1'b0;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (|bus.i_req) begin
          gnt_d[win_idx] = 1'b1;
          dvd_d          = win_dvd;
          dvs_d          = win_dvs;
          owner_d        = win_idx;
          last_d         = win_idx;
`ifdef DIV_ZERO_BYPASS_EN
          if (win_dvs == '0) begin
            // Saturate toward the dividend's sign; the divider stays idle.
            ovf_d   = 1'b1;
            quot_d  = win_dvd[N-1] ? {1'b1, {(N-1){1'b0}}}
                                   : {1'b0, {(N-1){1'b1}}};
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        start_d = 1'b1;
        state_d = S_GUARD;
      end
      S_GUARD: begin
        // The divider may still show the previous operation's complete level
        // while it samples the start pulse; do not look at it here.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_div_complete) begin
          quot_d  = bus.i_div_quotient;
          ovf_d   = bus.i_div_overflow;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        done_d[owner_q] = 1'b1;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      last_q  <= PW'(NREQ - 1);
      owner_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      start_q <= start_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.o_gnt          = gnt_q;
  assign bus.o_done         = done_q;
  assign bus.o_quotient     = quot_q;
  assign bus.o_overflow     = ovf_q;
  assign bus.o_busy         = (state_q != S_IDLE);
  assign bus.o_div_start    = start_q;
  assign bus.o_div_dividend = dvd_q;
  assign bus.o_div_divisor  = dvs_q;

endmodule
